// File: rtl/hazard_stall_ctrl_if.sv
// rtl/hazard_stall_ctrl_if.sv - hazard/stall controller bundle: pipeline hazard inputs and stall/flush controls

interface hazard_stall_ctrl_if #(
  parameter int REG_ADDR_W = 5,
  parameter int CNT_W      = 32
);
  logic [REG_ADDR_W-1:0] IFID_RsAddr_i;
  logic [REG_ADDR_W-1:0] IFID_RtAddr_i;
  logic                  IFID_UseRt_i;
  logic                  IFID_Branch_i;
  logic                  Branch_taken_i;
  logic                  IDEX_MemRead_i;
  logic                  IDEX_RegWrite_i;
  logic [REG_ADDR_W-1:0] IDEX_WriteAddr_i;
  logic                  EXMEM_MemRead_i;
  logic                  EXMEM_MemAcc_i;
  logic [REG_ADDR_W-1:0] EXMEM_WriteAddr_i;
  logic                  dmem_ready_i;
  logic                  PC_Write_o;
  logic                  IFID_Write_o;
  logic                  IFID_Flush_o;
  logic                  IDEX_Bubble_o;
  logic                  Pipe_Hold_o;
  logic [CNT_W-1:0]      stall_cycles_o;
  logic [CNT_W-1:0]      flush_cnt_o;

  // Pipeline side: supplies stage state, consumes the enables.
  modport master (
    output IFID_RsAddr_i, IFID_RtAddr_i, IFID_UseRt_i, IFID_Branch_i, Branch_taken_i,
    output IDEX_MemRead_i, IDEX_RegWrite_i, IDEX_WriteAddr_i,
    output EXMEM_MemRead_i, EXMEM_MemAcc_i, EXMEM_WriteAddr_i, dmem_ready_i,
    input  PC_Write_o, IFID_Write_o, IFID_Flush_o, IDEX_Bubble_o, Pipe_Hold_o,
    input  stall_cycles_o, flush_cnt_o
  );

  modport slave (
    input  IFID_RsAddr_i, IFID_RtAddr_i, IFID_UseRt_i, IFID_Branch_i, Branch_taken_i,
    input  IDEX_MemRead_i, IDEX_RegWrite_i, IDEX_WriteAddr_i,
    input  EXMEM_MemRead_i, EXMEM_MemAcc_i, EXMEM_WriteAddr_i, dmem_ready_i,
    output PC_Write_o, IFID_Write_o, IFID_Flush_o, IDEX_Bubble_o, Pipe_Hold_o,
    output stall_cycles_o, flush_cnt_o
  );
endinterface

// File: rtl/hazard_stall_ctrl.sv
// rtl/hazard_stall_ctrl.sv - load-use/branch/dmem-wait stall and flush controller
// Optional stall/flush performance counters enabled by HAZARD_PERF_CNT_EN.

module hazard_stall_ctrl #(
  parameter int REG_ADDR_W    = 5,
  parameter int BR_LOAD_STALL = 2,
  parameter int CNT_W         = 32
) (
  input  logic                clk_i,
  input  logic                rst_i,
  hazard_stall_ctrl_if.slave  bus
);
  typedef enum logic [1:0] {RUN, STALL, MEM_WAIT} state_t;

  state_t     state_q, state_d, eff_state;
  logic [1:0] cnt_q, cnt_d;

  logic [REG_ADDR_W-1:0] ex_dst, mem_dst;
  logic match_ex, match_mem, ld_br_haz, one_haz, mem_hold;
  logic pc_write, ifid_write, ifid_flush, idex_bubble, pipe_hold;

  always_comb begin
    ex_dst    = bus.IDEX_WriteAddr_i;
    mem_dst   = bus.EXMEM_WriteAddr_i;
    match_ex  = (ex_dst != '0) &&
                ((ex_dst == bus.IFID_RsAddr_i) || (bus.IFID_UseRt_i && (ex_dst == bus.IFID_RtAddr_i)));
    match_mem = (mem_dst != '0) &&
                ((mem_dst == bus.IFID_RsAddr_i) || (bus.IFID_UseRt_i && (mem_dst == bus.IFID_RtAddr_i)));
    ld_br_haz = bus.IFID_Branch_i && bus.IDEX_MemRead_i && match_ex;
    one_haz   = (bus.IDEX_MemRead_i && match_ex) ||
                (bus.IFID_Branch_i && bus.IDEX_RegWrite_i && match_ex) ||
                (bus.IFID_Branch_i && bus.EXMEM_MemRead_i && match_mem);
    mem_hold  = bus.EXMEM_MemAcc_i && !bus.dmem_ready_i;

    // The dmem-ready cycle of MEM_WAIT already behaves as the state it returns to,
    // so the remaining stall follows the hold with no idle gap.
    eff_state = state_q;
    if (state_q == MEM_WAIT) eff_state = (cnt_q != 2'd0) ? STALL : RUN;

    state_d     = state_q;
    cnt_d       = cnt_q;
    pc_write    = 1'b1;
    ifid_write  = 1'b1;
    ifid_flush  = 1'b0;
    idex_bubble = 1'b0;
    pipe_hold   = 1'b0;

    if (mem_hold) begin
      state_d    = MEM_WAIT;
      pc_write   = 1'b0;
      ifid_write = 1'b0;
      pipe_hold  = 1'b1;
    end else if (eff_state == STALL) begin
      pc_write    = 1'b0;
      ifid_write  = 1'b0;
      idex_bubble = 1'b1;
      cnt_d       = (cnt_q == 2'd0) ? 2'd0 : cnt_q - 2'd1;
      state_d     = (cnt_q <= 2'd1) ? RUN : STALL;
    end else if (ld_br_haz || one_haz) begin
      pc_write    = 1'b0;
      ifid_write  = 1'b0;
      idex_bubble = 1'b1;
      state_d     = RUN;
      if (ld_br_haz && (BR_LOAD_STALL > 1)) begin
        state_d = STALL;
        cnt_d   = 2'(BR_LOAD_STALL - 1);
      end
    end else begin
      state_d    = RUN;
      ifid_flush = bus.IFID_Branch_i && bus.Branch_taken_i;
    end

    // Reset drives the pipe into a bubbling freeze regardless of state.
    if (!rst_i) begin
      pc_write    = 1'b0;
      ifid_write  = 1'b0;
      ifid_flush  = 1'b0;
      idex_bubble = 1'b1;
      pipe_hold   = 1'b0;
    end
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_q <= RUN;
      cnt_q   <= 2'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  assign bus.PC_Write_o    = pc_write;
  assign bus.IFID_Write_o  = ifid_write;
  assign bus.IFID_Flush_o  = ifid_flush;
  assign bus.IDEX_Bubble_o = idex_bubble;
  assign bus.Pipe_Hold_o   = pipe_hold;

`ifdef HAZARD_PERF_CNT_EN
  logic [CNT_W-1:0] stall_cycles_q, stall_cycles_d, flush_cnt_q, flush_cnt_d;

  always_comb begin
    stall_cycles_d = stall_cycles_q;
    flush_cnt_d    = flush_cnt_q;
    if (!pc_write && (stall_cycles_q != {CNT_W{1'b1}})) stall_cycles_d = stall_cycles_q + 1'b1;
    if (ifid_flush && (flush_cnt_q != {CNT_W{1'b1}}))   flush_cnt_d    = flush_cnt_q + 1'b1;
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      stall_cycles_q <= '0;
      flush_cnt_q    <= '0;
    end else begin
      stall_cycles_q <= stall_cycles_d;
      flush_cnt_q    <= flush_cnt_d;
    end
  end

  assign bus.stall_cycles_o = stall_cycles_q;
  assign bus.flush_cnt_o    = flush_cnt_q;
`else
  assign bus.stall_cycles_o = {CNT_W{1'b0}};
  assign bus.flush_cnt_o    = {CNT_W{1'b0}};
`endif
endmodule

// File: tb/tb_hazard_stall_ctrl.sv
// tb/tb_hazard_stall_ctrl.sv - directed self-checking bench for hazard_stall_ctrl

module tb_hazard_stall_ctrl;
  localparam logic [4:0] IDLE = 5'b11000;
  localparam logic [4:0] STL  = 5'b00010;
  localparam logic [4:0] HLD  = 5'b00001;
  localparam logic [4:0] FLS  = 5'b11100;
  localparam logic [4:0] RSTV = 5'b00010;
`ifdef HAZARD_PERF_CNT_EN
  localparam bit PERF = 1'b1;
`else
  localparam bit PERF = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   n_cmp = 0;
  int   n_fail = 0;
  int   exp_stall = 0;
  int   exp_flush = 0;
  logic [4:0]  obs;
  logic [31:0] want;

  always #5 clk = ~clk;

  hazard_stall_ctrl_if #(.REG_ADDR_W(5), .CNT_W(32)) bus ();

  hazard_stall_ctrl #(.REG_ADDR_W(5), .BR_LOAD_STALL(2), .CNT_W(32)) dut (
    .clk_i (clk),
    .rst_i (rst_n),
    .bus   (bus.slave)
  );

  assign obs = {bus.PC_Write_o, bus.IFID_Write_o, bus.IFID_Flush_o, bus.IDEX_Bubble_o, bus.Pipe_Hold_o};

  task automatic clr_inputs();
    bus.IFID_RsAddr_i     = '0;
    bus.IFID_RtAddr_i     = '0;
    bus.IFID_UseRt_i      = 1'b0;
    bus.IFID_Branch_i     = 1'b0;
    bus.Branch_taken_i    = 1'b0;
    bus.IDEX_MemRead_i    = 1'b0;
    bus.IDEX_RegWrite_i   = 1'b0;
    bus.IDEX_WriteAddr_i  = '0;
    bus.EXMEM_MemRead_i   = 1'b0;
    bus.EXMEM_MemAcc_i    = 1'b0;
    bus.EXMEM_WriteAddr_i = '0;
    bus.dmem_ready_i      = 1'b1;
  endtask

  task automatic test_reset();
    clr_inputs();
    #1;
    n_cmp++;
    if (obs !== RSTV) begin $display("FAIL reset_out got=%b exp=%b", obs, RSTV); n_fail++; end
    n_cmp++;
    if (bus.stall_cycles_o !== 32'd0) begin $display("FAIL reset_stall_cnt got=%0d exp=0", bus.stall_cycles_o); n_fail++; end
    @(negedge clk); @(negedge clk);
    rst_n = 1'b1;
    #1;
    n_cmp++;
    if (obs !== IDLE) begin $display("FAIL reset_release got=%b exp=%b", obs, IDLE); n_fail++; end
  endtask

  task automatic test_load_use();
    @(negedge clk); clr_inputs();
    bus.IDEX_MemRead_i = 1'b1; bus.IDEX_RegWrite_i = 1'b1; bus.IDEX_WriteAddr_i = 5'd8;
    bus.IFID_RsAddr_i = 5'd8;
    #1; n_cmp++; exp_stall++;
    if (obs !== STL) begin $display("FAIL load_use_stall got=%b exp=%b", obs, STL); n_fail++; end
    @(negedge clk); clr_inputs();
    bus.IFID_RsAddr_i = 5'd8;
    bus.EXMEM_MemRead_i = 1'b1; bus.EXMEM_MemAcc_i = 1'b1; bus.EXMEM_WriteAddr_i = 5'd8;
    #1; n_cmp++;
    if (obs !== IDLE) begin $display("FAIL load_use_after got=%b exp=%b", obs, IDLE); n_fail++; end
  endtask

  task automatic test_load_r0();
    @(negedge clk); clr_inputs();
    bus.IDEX_MemRead_i = 1'b1; bus.IDEX_RegWrite_i = 1'b1; bus.IDEX_WriteAddr_i = 5'd0;
    #1; n_cmp++;
    if (obs !== IDLE) begin $display("FAIL load_r0 got=%b exp=%b", obs, IDLE); n_fail++; end
    // rt only counts when the instruction actually reads it
    @(negedge clk); clr_inputs();
    bus.IDEX_MemRead_i = 1'b1; bus.IDEX_WriteAddr_i = 5'd8; bus.IFID_RsAddr_i = 5'd2; bus.IFID_RtAddr_i = 5'd8;
    #1; n_cmp++;
    if (obs !== IDLE) begin $display("FAIL rt_unused got=%b exp=%b", obs, IDLE); n_fail++; end
    bus.IFID_UseRt_i = 1'b1;
    #1; n_cmp++; exp_stall++;
    if (obs !== STL) begin $display("FAIL rt_used got=%b exp=%b", obs, STL); n_fail++; end
  endtask

  task automatic test_branch_load();
    @(negedge clk); clr_inputs();
    bus.IDEX_MemRead_i = 1'b1; bus.IDEX_RegWrite_i = 1'b1; bus.IDEX_WriteAddr_i = 5'd9;
    bus.IFID_Branch_i = 1'b1; bus.Branch_taken_i = 1'b1; bus.IFID_RsAddr_i = 5'd9;
    bus.IFID_RtAddr_i = 5'd3; bus.IFID_UseRt_i = 1'b1;
    #1; n_cmp++; exp_stall++;
    if (obs !== STL) begin $display("FAIL br_load_c0 got=%b exp=%b", obs, STL); n_fail++; end
    @(negedge clk);
    bus.IDEX_MemRead_i = 1'b0; bus.IDEX_RegWrite_i = 1'b0; bus.IDEX_WriteAddr_i = 5'd0;
    bus.EXMEM_MemRead_i = 1'b1; bus.EXMEM_MemAcc_i = 1'b1; bus.EXMEM_WriteAddr_i = 5'd9;
    #1; n_cmp++; exp_stall++;
    if (obs !== STL) begin $display("FAIL br_load_c1 got=%b exp=%b", obs, STL); n_fail++; end
    @(negedge clk);
    bus.EXMEM_MemRead_i = 1'b0; bus.EXMEM_MemAcc_i = 1'b0; bus.EXMEM_WriteAddr_i = 5'd0;
    #1; n_cmp++; exp_flush++;
    if (obs !== FLS) begin $display("FAIL br_load_resolve got=%b exp=%b", obs, FLS); n_fail++; end
  endtask

  task automatic test_taken_branch();
    @(negedge clk); clr_inputs();
    bus.IFID_Branch_i = 1'b1; bus.Branch_taken_i = 1'b1; bus.IFID_RsAddr_i = 5'd4;
    #1; n_cmp++; exp_flush++;
    if (obs !== FLS) begin $display("FAIL taken_flush got=%b exp=%b", obs, FLS); n_fail++; end
    @(negedge clk); clr_inputs();
    bus.IFID_Branch_i = 1'b1; bus.IFID_RsAddr_i = 5'd4;
    #1; n_cmp++;
    if (obs !== IDLE) begin $display("FAIL not_taken got=%b exp=%b", obs, IDLE); n_fail++; end
    @(negedge clk); clr_inputs();
    want = PERF ? 32'(exp_flush) : 32'd0;
    n_cmp++;
    if (bus.flush_cnt_o !== want) begin $display("FAIL flush_cnt got=%0d exp=%0d", bus.flush_cnt_o, want); n_fail++; end
    want = PERF ? 32'(exp_stall) : 32'd0;
    n_cmp++;
    if (bus.stall_cycles_o !== want) begin $display("FAIL stall_cnt got=%0d exp=%0d", bus.stall_cycles_o, want); n_fail++; end
  endtask

  task automatic test_back_to_back();
    @(negedge clk); clr_inputs();
    bus.IFID_Branch_i = 1'b1; bus.Branch_taken_i = 1'b1; bus.IFID_RsAddr_i = 5'd5;
    bus.IDEX_RegWrite_i = 1'b1; bus.IDEX_WriteAddr_i = 5'd5;
    #1; n_cmp++;
    if (obs !== STL) begin $display("FAIL br_alu_dep got=%b exp=%b", obs, STL); n_fail++; end
    @(negedge clk);
    bus.IDEX_RegWrite_i = 1'b0; bus.IDEX_WriteAddr_i = 5'd0;
    bus.EXMEM_MemRead_i = 1'b1; bus.EXMEM_MemAcc_i = 1'b1; bus.EXMEM_WriteAddr_i = 5'd5;
    #1; n_cmp++;
    if (obs !== STL) begin $display("FAIL br_mem_load_dep got=%b exp=%b", obs, STL); n_fail++; end
    bus.dmem_ready_i = 1'b0;
    #1; n_cmp++;
    if (obs !== HLD) begin $display("FAIL hold_over_hazard got=%b exp=%b", obs, HLD); n_fail++; end
    @(negedge clk); clr_inputs();
    bus.IFID_Branch_i = 1'b1; bus.IFID_RsAddr_i = 5'd5;
    #1; n_cmp++;
    if (obs !== IDLE) begin $display("FAIL b2b_after got=%b exp=%b", obs, IDLE); n_fail++; end
  endtask

  task automatic test_mem_wait_stall();
    @(negedge clk); clr_inputs(); rst_n = 1'b0;
    @(negedge clk); rst_n = 1'b1;
    bus.IDEX_MemRead_i = 1'b1; bus.IDEX_RegWrite_i = 1'b1; bus.IDEX_WriteAddr_i = 5'd9;
    bus.IFID_Branch_i = 1'b1; bus.Branch_taken_i = 1'b1; bus.IFID_RsAddr_i = 5'd9;
    #1; n_cmp++;
    if (obs !== STL) begin $display("FAIL mw_first got=%b exp=%b", obs, STL); n_fail++; end
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      bus.IDEX_MemRead_i = 1'b0; bus.IDEX_RegWrite_i = 1'b0; bus.IDEX_WriteAddr_i = 5'd0;
      bus.EXMEM_MemAcc_i = 1'b1; bus.dmem_ready_i = 1'b0;
      #1; n_cmp++;
      if (obs !== HLD) begin $display("FAIL mw_hold%0d got=%b exp=%b", i, obs, HLD); n_fail++; end
    end
    @(negedge clk); bus.dmem_ready_i = 1'b1;
    #1; n_cmp++;
    if (obs !== STL) begin $display("FAIL mw_remaining got=%b exp=%b", obs, STL); n_fail++; end
    @(negedge clk); clr_inputs();
    #1; n_cmp++;
    if (obs !== IDLE) begin $display("FAIL mw_done got=%b exp=%b", obs, IDLE); n_fail++; end
    want = PERF ? 32'd5 : 32'd0;
    n_cmp++;
    if (bus.stall_cycles_o !== want) begin $display("FAIL mw_stall_cnt got=%0d exp=%0d", bus.stall_cycles_o, want); n_fail++; end
  endtask

  task automatic test_reset_mid_stall();
    @(negedge clk); clr_inputs();
    bus.IDEX_MemRead_i = 1'b1; bus.IDEX_WriteAddr_i = 5'd9;
    bus.IFID_Branch_i = 1'b1; bus.Branch_taken_i = 1'b1; bus.IFID_RsAddr_i = 5'd9;
    #1; n_cmp++;
    if (obs !== STL) begin $display("FAIL rms_enter got=%b exp=%b", obs, STL); n_fail++; end
    @(negedge clk);
    bus.IDEX_MemRead_i = 1'b0; bus.EXMEM_MemAcc_i = 1'b1; bus.dmem_ready_i = 1'b0;
    rst_n = 1'b0;
    #1; n_cmp++;
    if (obs !== RSTV) begin $display("FAIL rms_in_reset got=%b exp=%b", obs, RSTV); n_fail++; end
    n_cmp++;
    if (bus.stall_cycles_o !== 32'd0) begin $display("FAIL rms_cnt_clear got=%0d exp=0", bus.stall_cycles_o); n_fail++; end
    @(negedge clk); clr_inputs(); rst_n = 1'b1;
    #1; n_cmp++;
    if (obs !== IDLE) begin $display("FAIL rms_release got=%b exp=%b", obs, IDLE); n_fail++; end
    @(negedge clk);
    #1; n_cmp++;
    if (obs !== IDLE) begin $display("FAIL rms_no_residual got=%b exp=%b", obs, IDLE); n_fail++; end
  endtask

  initial begin
    test_reset();
    test_load_use();
    test_load_r0();
    test_branch_load();
    test_taken_branch();
    test_back_to_back();
    test_mem_wait_stall();
    test_reset_mid_stall();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule
